// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types: cacheline/beat widths and line type
package rv32i_types;

    localparam int LINE_WIDTH = 256;
    localparam int BEAT_WIDTH = 64;
    localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;

    typedef logic [LINE_WIDTH-1:0] line_t;

    // Clears the byte-within-line offset so bursts always start on a line boundary
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:5], 5'b0};
    endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// rtl/line_beat_buffer.sv - 256-bit line register with beat-indexed write port and read mux
module line_beat_buffer
    import rv32i_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [LINE_WIDTH-1:0] load_data,
    input  logic                  beat_we,
    input  logic [1:0]            beat_idx,
    input  logic [BEAT_WIDTH-1:0] beat_wdata,
    output logic [LINE_WIDTH-1:0] line_q,
    output logic [BEAT_WIDTH-1:0] beat_rdata
);

    line_t data_q;

    // Whole-line load wins over a single-beat update; the adaptor never asks for both at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else if (load_en) begin
            data_q <= load_data;
        end else if (beat_we) begin
            data_q[BEAT_WIDTH*beat_idx +: BEAT_WIDTH] <= beat_wdata;
        end
    end

    assign line_q     = data_q;
    assign beat_rdata = data_q[BEAT_WIDTH*beat_idx +: BEAT_WIDTH];

endmodule

// File: rtl/line_burst_adaptor.sv
// rtl/line_burst_adaptor.sv - 256-bit line to 4x64-bit burst adaptor; LINE_ADAPTOR_FAST_RESP_EN drops the DONE cycle
module line_burst_adaptor
    import rv32i_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_read,
    input  logic                  line_write,
    input  logic [31:0]           line_address,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    output logic                  line_resp,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [31:0]           burst_address,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [31:0] addr_q;

    logic        in_burst;
    logic        last_beat;
    logic        buf_load;
    logic        buf_beat_we;
    line_t       buf_line;
    logic [BEAT_WIDTH-1:0] buf_beat;

    assign in_burst    = (state_q == RD_BURST) || (state_q == WR_BURST);
    assign last_beat   = in_burst && burst_resp && (cnt_q == 2'd3);
    assign buf_load    = (state_q == IDLE) && line_write;
    assign buf_beat_we = (state_q == RD_BURST) && burst_resp;

    line_beat_buffer u_buffer (
        .clk        (clk),
        .rst        (rst),
        .load_en    (buf_load),
        .load_data  (line_wdata),
        .beat_we    (buf_beat_we),
        .beat_idx   (cnt_q),
        .beat_wdata (burst_rdata),
        .line_q     (buf_line),
        .beat_rdata (buf_beat)
    );

    // Transaction sequencer: requests are only looked at in IDLE, beats advance on burst_resp
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= 2'd0;
                    if (line_write) begin
                        state_q <= WR_BURST;
                        addr_q  <= line_align(line_address);
                    end else if (line_read) begin
                        state_q <= RD_BURST;
                        addr_q  <= line_align(line_address);
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (burst_resp) begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                    if (last_beat) begin
`ifdef LINE_ADAPTOR_FAST_RESP_EN
                        state_q <= IDLE;
`else
                        state_q <= DONE;
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign burst_read    = (state_q == RD_BURST);
    assign burst_write   = (state_q == WR_BURST);
    assign burst_address = addr_q;
    assign burst_wdata   = (state_q == WR_BURST) ? buf_beat : '0;

`ifdef LINE_ADAPTOR_FAST_RESP_EN
    // The final read beat bypasses the buffer so the line is complete in the same cycle
    assign line_resp  = last_beat;
    assign line_rdata = ((state_q == RD_BURST) && last_beat)
                        ? {burst_rdata, buf_line[LINE_WIDTH-BEAT_WIDTH-1:0]}
                        : buf_line;
`else
    assign line_resp  = (state_q == DONE);
    assign line_rdata = buf_line;
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// tb/tb_line_burst_adaptor.sv - self-checking bench for line_burst_adaptor
module tb_line_burst_adaptor;
    import rv32i_types::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  line_read;
    logic                  line_write;
    logic [31:0]           line_address;
    logic [LINE_WIDTH-1:0] line_wdata;
    logic                  line_resp;
    logic [LINE_WIDTH-1:0] line_rdata;
    logic                  burst_read;
    logic                  burst_write;
    logic [31:0]           burst_address;
    logic [BEAT_WIDTH-1:0] burst_wdata;
    logic [BEAT_WIDTH-1:0] burst_rdata;
    logic                  burst_resp;

    int n_checks = 0;
    int n_errors = 0;
    bit fast;
    logic [63:0] src [4];

    line_burst_adaptor dut (
        .clk           (clk),
        .rst           (rst),
        .line_read     (line_read),
        .line_write    (line_write),
        .line_address  (line_address),
        .line_wdata    (line_wdata),
        .line_resp     (line_resp),
        .line_rdata    (line_rdata),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_address (burst_address),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_line_resp"}, line_resp, 0);
        check({tag, "_line_rdata"}, line_rdata, 0);
        check({tag, "_burst_read"}, burst_read, 0);
        check({tag, "_burst_write"}, burst_write, 0);
        check({tag, "_burst_address"}, burst_address, 0);
        check({tag, "_burst_wdata"}, burst_wdata, 0);
    endtask

    // One line transaction against a memory model that inserts wait cycles before each beat.
    // Called at a negedge; returns at the +1ns point of the idle cycle following line_resp.
    task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr, input line_t wdata,
                           input int wait_lo, input int wait_hi, input bit hold_read, input bit spur);
        int    waits [4];
        int    total = 0;
        int    cyc;
        int    beat;
        int    w_left;
        int    resp_cyc = -1;
        bit    r;
        bit    is_wr;
        line_t exp_line;
        logic [31:0] exp_addr;

        for (int i = 0; i < 4; i++) begin
            waits[i] = $urandom_range(wait_hi, wait_lo);
            total += waits[i];
        end
        is_wr    = wr;
        exp_addr = addr & 32'hFFFF_FFE0;
        exp_line = is_wr ? wdata : {src[3], src[2], src[1], src[0]};

        line_read    = rd;
        line_write   = wr;
        line_address = addr;
        line_wdata   = wdata;
        @(negedge clk);
        line_write   = 1'b0;
        line_read    = hold_read ? rd : 1'b0;
        line_wdata   = rand_line();
        line_address = $urandom;

        cyc    = 1;
        beat   = 0;
        w_left = waits[0];
        while (beat < 4 && cyc < 100) begin
            r = (w_left == 0);
            burst_resp  = r;
            burst_rdata = r ? src[beat] : {$urandom, $urandom};
            #1;
            check("burst_read", burst_read, !is_wr);
            check("burst_write", burst_write, is_wr);
            check("burst_address", burst_address, exp_addr);
            if (is_wr) check("burst_wdata", burst_wdata, wdata[64*beat +: 64]);
            check("line_resp_during_burst", line_resp, fast && r && beat == 3);
            if (fast && r && beat == 3) begin
                resp_cyc = cyc;
                if (!is_wr) check("line_rdata", line_rdata, exp_line);
            end
            if (r) begin
                beat++;
                if (beat < 4) w_left = waits[beat];
            end else begin
                w_left--;
            end
            @(negedge clk);
            cyc++;
        end
        if (beat < 4) check("burst_timeout", beat, 4);
        burst_resp = 1'b0;

        if (!fast) begin
            if (spur) begin
                burst_resp  = 1'b1;
                burst_rdata = {$urandom, $urandom};
            end
            #1;
            check("line_resp_done", line_resp, 1);
            resp_cyc = cyc;
            if (!is_wr) check("line_rdata", line_rdata, exp_line);
            check("burst_read_done", burst_read, 0);
            check("burst_write_done", burst_write, 0);
            @(negedge clk);
            cyc++;
        end

        if (spur) begin
            burst_resp  = 1'b1;
            burst_rdata = {$urandom, $urandom};
        end
        #1;
        check("line_resp_idle", line_resp, 0);
        check("burst_read_idle", burst_read, 0);
        check("burst_write_idle", burst_write, 0);
        check("latency", resp_cyc, 4 + total + (fast ? 0 : 1));
    endtask

    initial begin
`ifdef LINE_ADAPTOR_FAST_RESP_EN
        fast = 1'b1;
`else
        fast = 1'b0;
`endif
        rst          = 1'b0;
        line_read    = 1'b0;
        line_write   = 1'b0;
        line_address = 32'd0;
        line_wdata   = '0;
        burst_rdata  = '0;
        burst_resp   = 1'b0;

        // Reset held with noisy inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            burst_resp   = ~burst_resp;
            burst_rdata  = {$urandom, $urandom};
            line_read    = $urandom_range(1, 0);
            line_write   = $urandom_range(1, 0);
            line_address = $urandom;
            line_wdata   = rand_line();
            #1;
            check_all_zero("reset");
        end
        @(negedge clk);
        burst_resp = 1'b0;
        line_read  = 1'b0;
        line_write = 1'b0;
        rst        = 1'b1;
        @(negedge clk);

        // Zero-wait read at an unaligned address
        src[0] = 64'h1111_1111_1111_1111;
        src[1] = 64'h2222_2222_2222_2222;
        src[2] = 64'h3333_3333_3333_3333;
        src[3] = 64'h4444_4444_4444_4444;
        run_txn(1'b0, 1'b1, 32'h0000_1234, '0, 0, 0, 1'b0, 1'b0);

        // Write with two wait cycles before every beat
        run_txn(1'b1, 1'b0, 32'h8000_0040,
                {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                2, 2, 1'b0, 1'b0);

        // Simultaneous read and write: write wins; read stays held across line_resp
        run_txn(1'b1, 1'b1, 32'h0000_2000, rand_line(), 0, 1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) src[i] = {$urandom, $urandom};
        run_txn(1'b0, 1'b1, 32'h0000_3000, '0, 0, 1, 1'b0, 1'b0);

        // Reset during a read after two beats
        for (int i = 0; i < 4; i++) src[i] = {$urandom, $urandom};
        line_read    = 1'b1;
        line_address = 32'h0000_4444;
        @(negedge clk);
        line_read = 1'b0;
        for (int b = 0; b < 2; b++) begin
            burst_resp  = 1'b1;
            burst_rdata = src[b];
            @(negedge clk);
        end
        burst_resp = 1'b0;
        #1;
        check("burst_read_before_reset", burst_read, 1);
        rst = 1'b0;
        #1;
        check("burst_read_async_reset", burst_read, 0);
        check("line_resp_async_reset", line_resp, 0);
        check("line_rdata_async_reset", line_rdata, 0);
        @(negedge clk);
        check("line_resp_in_reset", line_resp, 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("line_resp_after_reset", line_resp, 0);
        check("burst_read_after_reset", burst_read, 0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) src[i] = {$urandom, $urandom};
        run_txn(1'b0, 1'b1, 32'h0000_4444, '0, 0, 0, 1'b0, 1'b0);

        // Spurious burst_resp while idle, then a transaction with pulses in DONE and idle
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            burst_resp  = 1'b1;
            burst_rdata = {$urandom, $urandom};
            @(negedge clk);
            #1;
            check("spur_idle_line_resp", line_resp, 0);
            check("spur_idle_burst_read", burst_read, 0);
        end
        burst_resp = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) src[i] = {$urandom, $urandom};
        run_txn(1'b0, 1'b1, 32'h0000_5000, '0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) src[i] = {$urandom, $urandom};
        run_txn(1'b0, 1'b1, 32'h0000_6000, '0, 0, 0, 1'b0, 1'b0);

        // Random mix of reads and writes with random wait states
        for (int t = 0; t < 20; t++) begin
            bit wr;
            wr = $urandom_range(1, 0);
            for (int i = 0; i < 4; i++) src[i] = {$urandom, $urandom};
            run_txn(wr, !wr, $urandom, rand_line(), 0, 3, 1'b0, 1'b0);
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
